// File: rtl/sim_result_checker.sv
// ---------------------------------------------------------------------------
// sim_result_checker
//
// End-of-test monitor for the RV32I core, built from synthesisable logic
// only so the same check runs in simulation and on an FPGA.
//
// The checker watches the data-memory write port for the end-signature
// write. A watchdog stops runaway tests. After the end write or a
// watchdog timeout, the checker stalls the core and waits a few drain
// cycles. It then takes over the DM read port and compares the result
// region against a golden ROM. It reports pass/fail, the error count, the
// first failing index and the cycle statistics.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   snoop_ceb/web       DM chip enable / byte write enables (active low)
//   snoop_addr/di       DM write word address / data
//   num_golden          number of valid golden words (0..MAX_WORDS)
//   halt_req            core stall; the checker owns the DM port
//   rd_en/rd_addr       checker DM read strobe / address
//   rd_data             DM read data, one cycle after rd_en
//   gold_addr/gold_data golden ROM index (issued with rd_en) / word
//   done, pass          check finished (sticky) / test passed
//   timeout             watchdog fired (sticky)
//   err_cnt, first_err  mismatch count / index of the first mismatch
//   cycle_cnt           saturating cycle counter (runs while in RUN)
//   end_cycle           cycle_cnt at end detection or timeout
//   rd_cycle_lo/hi      two words after the results (RDCYCLE_EN only)
// ---------------------------------------------------------------------------
module sim_result_checker #(
    parameter int                ADDR_W     = 14,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] END_ADDR   = 'h3fff,
    parameter logic [DATA_W-1:0] END_CODE   = '1,
    parameter logic [ADDR_W-1:0] TEST_START = 'h2000,
    parameter int                MAX_WORDS  = 64,
    parameter int                MAX_CYCLE  = 100000,
    parameter int                DRAIN_CYC  = 4,
    parameter bit                RDCYCLE_EN = 1'b0,
    localparam int               CNT_W      = $clog2(MAX_WORDS + 1),
    localparam int               IDX_W      = $clog2(MAX_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snoop_ceb,
    input  logic [3:0]        snoop_web,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic [DATA_W-1:0] snoop_di,
    input  logic [CNT_W-1:0]  num_golden,
    output logic              halt_req,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  gold_addr,
    input  logic [DATA_W-1:0] gold_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [IDX_W-1:0]  first_err,
    output logic [63:0]       cycle_cnt,
    output logic [63:0]       end_cycle,
    output logic [DATA_W-1:0] rd_cycle_lo,
    output logic [DATA_W-1:0] rd_cycle_hi
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        DRAIN = 3'd1,
        CHECK = 3'd2,
        CYCRD = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int              DR_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYC - 1);
    localparam logic [63:0]     WD_LAST = 64'(MAX_CYCLE - 1);

    state_t            state;
    logic [DR_W-1:0]   drain_cnt;
    logic [CNT_W-1:0]  idx;        // reads issued so far in CHECK
    logic              cmp_vld;    // rd_data/gold_data hold a compare operand
    logic [IDX_W-1:0]  cmp_idx;    // golden index of the operand in flight
    logic [1:0]        cyc_ph;

    logic              end_hit;
    logic              wd_hit;
    logic              mismatch;
    logic [CNT_W-1:0]  err_nxt;
    logic [ADDR_W-1:0] tail_addr;

    // Only a full-word write of the signature counts. Partial writes and
    // writes with the chip disabled are ignored.
    assign end_hit   = !snoop_ceb && (snoop_web == 4'b0000) &&
                       (snoop_addr == END_ADDR) && (snoop_di == END_CODE);
    assign wd_hit    = (cycle_cnt == WD_LAST);
    // A read issued in the previous cycle returns its data now. The
    // compare is only meaningful while walking the golden region.
    assign mismatch  = (state == CHECK) && cmp_vld && (rd_data != gold_data);
    assign err_nxt   = err_cnt + CNT_W'(mismatch);
    assign tail_addr = TEST_START + ADDR_W'(num_golden);

    // NOTE: every register here updates with <= so that all of them sample
    // the pre-edge values, whatever order the statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            drain_cnt   <= '0;
            idx         <= '0;
            cmp_vld     <= 1'b0;
            cmp_idx     <= '0;
            cyc_ph      <= '0;
            halt_req    <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            gold_addr   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            err_cnt     <= '0;
            first_err   <= '0;
            cycle_cnt   <= '0;
            end_cycle   <= '0;
            rd_cycle_lo <= '0;
            rd_cycle_hi <= '0;
        end else begin
            cmp_vld <= rd_en;
            cmp_idx <= gold_addr;

            case (state)
                RUN: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 64'd1;
                    end
                    // end_hit takes priority, so the watchdog cannot fire
                    // on the cycle the signature arrives.
                    if (end_hit || wd_hit) begin
                        timeout   <= !end_hit;
                        end_cycle <= cycle_cnt;
                        halt_req  <= 1'b1;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == DR_LAST) begin
                        state <= CHECK;
                        // The first read goes out with CHECK entry, so
                        // the reads run back to back from CHECK cycle 0.
                        if (num_golden != '0) begin
                            rd_en     <= 1'b1;
                            rd_addr   <= TEST_START;
                            gold_addr <= '0;
                            idx       <= CNT_W'(1);
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DR_W'(1);
                    end
                end

                CHECK: begin
                    err_cnt <= err_nxt;
                    if (mismatch && (err_cnt == '0)) begin
                        first_err <= cmp_idx;
                    end
                    if (!rd_en) begin
                        // No read went out this cycle, so this cycle
                        // carries the last compare (or there were none).
                        if (RDCYCLE_EN) begin
                            rd_en   <= 1'b1;
                            rd_addr <= tail_addr;
                            cyc_ph  <= '0;
                            state   <= CYCRD;
                        end else begin
                            done  <= 1'b1;
                            pass  <= !timeout && (err_nxt == '0);
                            state <= DONE;
                        end
                    end else if (idx < num_golden) begin
                        rd_addr   <= TEST_START + ADDR_W'(idx);
                        gold_addr <= IDX_W'(idx);
                        idx       <= idx + CNT_W'(1);
                    end else begin
                        rd_en <= 1'b0;
                    end
                end

                CYCRD: begin
                    // ph0: lo read out; ph1: hi read out, lo returns;
                    // ph2: hi returns.
                    case (cyc_ph)
                        2'd0: begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                            cyc_ph  <= 2'd1;
                        end
                        2'd1: begin
                            rd_cycle_lo <= rd_data;
                            rd_en       <= 1'b0;
                            cyc_ph      <= 2'd2;
                        end
                        default: begin
                            rd_cycle_hi <= rd_data;
                            done        <= 1'b1;
                            pass        <= !timeout && (err_cnt == '0);
                            state       <= DONE;
                        end
                    endcase
                end

                DONE: begin
                    rd_en <= 1'b0;
                end

                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_result_checker.sv
// ---------------------------------------------------------------------------
// tb_sim_result_checker
//
// Drives two checker instances with the same snoop traffic and DM image.
// One instance has the tail-word read disabled and one has it enabled;
// both use a 200-cycle watchdog. The bench plays the DM and the golden ROM.
// For every run, the expected read stream and final results come from
// the DM/golden contents and the run's end cycle. A monitor compares
// them as reads and done appear.
// ---------------------------------------------------------------------------
module tb_sim_result_checker;

    localparam int             AW    = 14;
    localparam int             DW    = 32;
    localparam int             MW    = 64;
    localparam int             CW    = 7;
    localparam int             IW    = 6;
    localparam int             WD    = 200;
    localparam logic [AW-1:0]  TS    = 14'h2000;
    localparam logic [AW-1:0]  END_A = 14'h3fff;

    typedef struct {
        logic [AW-1:0] addr;
        int            gidx;
        bit            has_gold;
        int            lat;      // cycles after halt_req rises
    } rd_t;

    typedef struct {
        bit          to;
        logic [63:0] endc;
        int          err;
        int          ferr;
        bit          pass;
        int          lat;
        logic [31:0] lo;
        logic [31:0] hi;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          snoop_ceb = 1'b1;
    logic [3:0]    snoop_web = 4'hf;
    logic [AW-1:0] snoop_addr = '0;
    logic [DW-1:0] snoop_di = '0;
    logic [CW-1:0] num_golden = '0;

    logic          halt_req [2];
    logic          rd_en [2];
    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] rd_data [2];
    logic [IW-1:0] gold_addr [2];
    logic [DW-1:0] gold_data [2];
    logic          done [2];
    logic          pass [2];
    logic          timeout [2];
    logic [CW-1:0] err_cnt [2];
    logic [IW-1:0] first_err [2];
    logic [63:0]   cycle_cnt [2];
    logic [63:0]   end_cycle [2];
    logic [DW-1:0] rd_lo [2];
    logic [DW-1:0] rd_hi [2];

    logic [DW-1:0] dm [0:(1<<AW)-1];
    logic [DW-1:0] gold [0:MW-1];

    int   tb_cyc;
    int   n_cmp = 0;
    int   n_bad = 0;
    rd_t  rdq0 [$];
    rd_t  rdq1 [$];
    res_t resq0 [$];
    res_t resq1 [$];
    bit   halt_q [2];
    bit   done_q [2];
    int   halt_t [2];

    always #5 clk = ~clk;

    sim_result_checker #(.MAX_CYCLE(WD), .RDCYCLE_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .snoop_ceb(snoop_ceb), .snoop_web(snoop_web),
        .snoop_addr(snoop_addr), .snoop_di(snoop_di),
        .num_golden(num_golden),
        .halt_req(halt_req[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .gold_addr(gold_addr[0]), .gold_data(gold_data[0]),
        .done(done[0]), .pass(pass[0]), .timeout(timeout[0]),
        .err_cnt(err_cnt[0]), .first_err(first_err[0]),
        .cycle_cnt(cycle_cnt[0]), .end_cycle(end_cycle[0]),
        .rd_cycle_lo(rd_lo[0]), .rd_cycle_hi(rd_hi[0])
    );

    sim_result_checker #(.MAX_CYCLE(WD), .RDCYCLE_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .snoop_ceb(snoop_ceb), .snoop_web(snoop_web),
        .snoop_addr(snoop_addr), .snoop_di(snoop_di),
        .num_golden(num_golden),
        .halt_req(halt_req[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .gold_addr(gold_addr[1]), .gold_data(gold_data[1]),
        .done(done[1]), .pass(pass[1]), .timeout(timeout[1]),
        .err_cnt(err_cnt[1]), .first_err(first_err[1]),
        .cycle_cnt(cycle_cnt[1]), .end_cycle(end_cycle[1]),
        .rd_cycle_lo(rd_lo[1]), .rd_cycle_hi(rd_hi[1])
    );

    // DM and golden ROM, both with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) rd_data[i] <= dm[rd_addr[i]];
            gold_data[i] <= gold[gold_addr[i]];
        end
    end

    // Mirrors the number of clock edges since reset release, which is
    // what the DUT's cycle counter reads while the test is running.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic string nm(input int id, input string s);
        return $sformatf("dut%0d_%s", id, s);
    endfunction

    task automatic pop_rd(input int id, output rd_t it, output bit ok);
        it = '{addr: '0, gidx: 0, has_gold: 1'b0, lat: 0};
        ok = 1'b0;
        if (id == 0 && rdq0.size() > 0) begin it = rdq0.pop_front(); ok = 1'b1; end
        if (id == 1 && rdq1.size() > 0) begin it = rdq1.pop_front(); ok = 1'b1; end
    endtask

    task automatic pop_res(input int id, output res_t r, output bit ok);
        r = '{to: 1'b0, endc: '0, err: 0, ferr: 0, pass: 1'b0, lat: 0, lo: '0, hi: '0};
        ok = 1'b0;
        if (id == 0 && resq0.size() > 0) begin r = resq0.pop_front(); ok = 1'b1; end
        if (id == 1 && resq1.size() > 0) begin r = resq1.pop_front(); ok = 1'b1; end
    endtask

    task automatic flush_queues();
        rdq0.delete();
        rdq1.delete();
        resq0.delete();
        resq1.delete();
    endtask

    // Monitor: one instance per negedge, decoupled from the stimulus.
    task automatic mon(input int id);
        rd_t  it;
        res_t r;
        bit   ok;
        if (halt_req[id] && !halt_q[id]) halt_t[id] = tb_cyc;
        if (rd_en[id]) begin
            pop_rd(id, it, ok);
            if (!ok) begin
                check(nm(id, "unexpected_read"), rd_en[id], 1'b0);
            end else begin
                check(nm(id, "rd_addr"), rd_addr[id], it.addr);
                if (it.has_gold) check(nm(id, "gold_addr"), gold_addr[id], it.gidx);
                check(nm(id, "rd_slot"), tb_cyc - halt_t[id], it.lat);
                check(nm(id, "halt_during_rd"), halt_req[id], 1'b1);
            end
        end
        if (done[id] && !done_q[id]) begin
            pop_res(id, r, ok);
            if (!ok) begin
                check(nm(id, "unexpected_done"), done[id], 1'b0);
            end else begin
                check(nm(id, "timeout"), timeout[id], r.to);
                check(nm(id, "end_cycle"), end_cycle[id], r.endc);
                check(nm(id, "err_cnt"), err_cnt[id], r.err);
                check(nm(id, "first_err"), first_err[id], r.ferr);
                check(nm(id, "pass"), pass[id], r.pass);
                check(nm(id, "done_latency"), tb_cyc - halt_t[id], r.lat);
                check(nm(id, "rd_cycle_lo"), rd_lo[id], r.lo);
                check(nm(id, "rd_cycle_hi"), rd_hi[id], r.hi);
                check(nm(id, "done_rd_en"), rd_en[id], 1'b0);
            end
        end
        halt_q[id] = halt_req[id];
        done_q[id] = done[id];
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                halt_q[i] = 1'b0;
                done_q[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    task automatic snoop_idle();
        snoop_ceb  = 1'b1;
        snoop_web  = 4'hf;
        snoop_addr = '0;
        snoop_di   = '0;
    endtask

    // Random DM traffic, biased towards near-misses on the signature.
    task automatic drive_noise(input bit allow_end);
        snoop_ceb  = 1'($urandom);
        snoop_web  = 4'($urandom);
        snoop_addr = AW'($urandom);
        snoop_di   = $urandom;
        case ($urandom_range(0, 4))
            0: begin  // partial-byte signature write
                snoop_ceb = 1'b0; snoop_addr = END_A; snoop_di = '1;
                snoop_web = 4'($urandom_range(1, 15));
            end
            1: begin  // chip disabled
                snoop_ceb = 1'b1; snoop_addr = END_A; snoop_di = '1; snoop_web = 4'h0;
            end
            2: begin  // wrong code, full write
                snoop_ceb = 1'b0; snoop_addr = END_A; snoop_web = 4'h0;
                snoop_di = ~(32'd1 << $urandom_range(0, 31));
            end
            3: if (allow_end) begin
                snoop_ceb = 1'b0; snoop_addr = END_A; snoop_web = 4'h0; snoop_di = '1;
            end
            default: ;
        endcase
        if (!allow_end && !snoop_ceb && snoop_web == 4'h0 &&
            snoop_addr == END_A && snoop_di == '1) snoop_ceb = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        snoop_idle();
        flush_queues();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check(nm(i, "rst_flags"), {done[i], pass[i], timeout[i], halt_req[i], rd_en[i]}, 5'b0);
            check(nm(i, "rst_err_idx"), {err_cnt[i], first_err[i], rd_addr[i], gold_addr[i]}, '0);
            check(nm(i, "rst_cycle_cnt"), cycle_cnt[i], 64'd0);
            check(nm(i, "rst_end_cycle"), end_cycle[i], 64'd0);
            check(nm(i, "rst_rd_cycle"), {rd_lo[i], rd_hi[i]}, 64'd0);
        end
        rst_n = 1'b1;
    endtask

    // mode: 0 end write at cycle e, 1 end write on the watchdog cycle,
    //       2 no end write (watchdog), 3 reset asserted during CHECK.
    // n_sel/e_sel < 0 pick randomly; corrupt_at >= 0 corrupts that word,
    // -1 corrupts a few random words, -2 corrupts nothing.
    task automatic run_one(input int mode, input int n_sel, input int e_sel, input int corrupt_at);
        int   n, e, err, ferr, budget, k;
        bit   hit, stop;
        res_t r;
        do_reset();

        if (n_sel >= 0) n = n_sel;
        else begin
            case ($urandom_range(0, 5))
                0: n = 0;
                1: n = 1;
                2: n = MW;
                default: n = $urandom_range(2, MW - 1);
            endcase
        end
        if (mode == 3 && n < 3) n = 3;
        num_golden = CW'(n);

        for (int j = 0; j < MW + 2; j++) dm[TS + AW'(j)] = $urandom;
        for (int j = 0; j < MW; j++) gold[j] = dm[TS + AW'(j)];
        if (corrupt_at >= 0) begin
            dm[TS + AW'(corrupt_at)] = ~dm[TS + AW'(corrupt_at)];
        end else if (corrupt_at == -1 && n > 0) begin
            repeat ($urandom_range(0, 3)) begin
                k = $urandom_range(0, n - 1);
                dm[TS + AW'(k)] = dm[TS + AW'(k)] ^ (32'd1 << $urandom_range(0, 31));
            end
        end
        // Words beyond the golden count may differ freely.
        for (int j = n; j < MW; j++) gold[j] = $urandom;

        if (mode == 2)      e = -1;
        else if (e_sel >= 0) e = e_sel;
        else if (mode == 1) e = WD - 1;
        else if (mode == 3) e = $urandom_range(3, 150);
        else                e = $urandom_range(3, WD - 2);

        err  = 0;
        ferr = 0;
        for (int j = 0; j < n; j++) begin
            if (dm[TS + AW'(j)] !== gold[j]) begin
                if (err == 0) ferr = j;
                err++;
            end
        end
        r.to   = (e < 0);
        r.endc = r.to ? 64'(WD - 1) : 64'(e);
        r.err  = err;
        r.ferr = ferr;
        r.pass = !r.to && (err == 0);
        for (int j = 0; j < n; j++) begin
            rdq0.push_back('{addr: TS + AW'(j), gidx: j, has_gold: 1'b1, lat: 4 + j});
            rdq1.push_back('{addr: TS + AW'(j), gidx: j, has_gold: 1'b1, lat: 4 + j});
        end
        rdq1.push_back('{addr: TS + AW'(n),     gidx: 0, has_gold: 1'b0, lat: n + 5});
        rdq1.push_back('{addr: TS + AW'(n + 1), gidx: 0, has_gold: 1'b0, lat: n + 6});
        r.lat = n + 5; r.lo = '0; r.hi = '0;
        resq0.push_back(r);
        r.lat = n + 8; r.lo = dm[TS + AW'(n)]; r.hi = dm[TS + AW'(n + 1)];
        resq1.push_back(r);

        hit    = 1'b0;
        stop   = 1'b0;
        budget = 800;
        while (!stop) begin
            @(negedge clk);
            if (done[0] && done[1]) begin
                stop = 1'b1;
            end else if (budget == 0) begin
                if (mode == 3) check("rd_seen_in_budget", rd_en[0], 1'b1);
                else           check("done_in_budget", {done[1], done[0]}, 2'b11);
                stop = 1'b1;
            end else begin
                budget--;
                if (mode == 3 && rd_en[0]) begin
                    #2;
                    flush_queues();
                    rst_n = 1'b0;
                    #1;
                    for (int i = 0; i < 2; i++) begin
                        check(nm(i, "async_rst_rd_en"), rd_en[i], 1'b0);
                        check(nm(i, "async_rst_halt"), halt_req[i], 1'b0);
                    end
                    stop = 1'b1;
                end else if (!hit && tb_cyc == e) begin
                    snoop_ceb = 1'b0; snoop_web = 4'h0; snoop_addr = END_A; snoop_di = '1;
                    hit = 1'b1;
                end else begin
                    drive_noise(hit || tb_cyc >= WD);
                end
            end
        end
        snoop_idle();
        if (mode != 3) begin
            repeat (3) @(negedge clk);
            check("pending_reads", rdq0.size() + rdq1.size(), 0);
            check("pending_results", resq0.size() + resq1.size(), 0);
        end
    endtask

    initial begin
        run_one(0, 4, 100, -2);   // clean pass, end at cycle 100
        run_one(0, 4, 100, 2);    // one corrupted word
        run_one(1, -1, -1, -1);   // end write on the watchdog cycle
        run_one(2, 4, -1, -2);    // watchdog timeout
        run_one(3, -1, -1, -1);   // reset during CHECK
        run_one(0, 0, -1, -1);    // empty golden region
        run_one(0, MW, -1, -1);   // full golden region
        run_one(0, 1, 3, 0);      // single word, early end
        for (int i = 0; i < 12; i++) run_one($urandom_range(0, 3), -1, -1, -1);
        run_one(0, 5, -1, -1);    // normal run after the random mix
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

endmodule
